mc_control_fsm: RTL

Multi-cycle control sequencer for the MIPS datapath once instruction and data memory are merged into one port. It sequences each instruction through fetch, decode, execute, memory and writeback states, and drives every datapath select and write strobe. It waits on a shared-memory ready handshake and replaces the combinational ControlUnit in the multi-cycle top.

---
 rtl/mips_pkg.sv | 58 +++++
 rtl/mc_control_fsm_alu_decoder.sv | 42 ++++
 rtl/mc_control_fsm.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: states, ALU codes,
// opcode/funct values and datapath select encodings.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_IMMEX   = 4'd9,
        S_IMMWB   = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    // Which rule the ALU decoder applies in the current state
    typedef enum logic [1:0] {
        CLS_ADD   = 2'd0,
        CLS_SUB   = 2'd1,
        CLS_FUNCT = 2'd2,
        CLS_IMM   = 2'd3
    } alu_class_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [1:0] SRCB_REG     = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUREG = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/mc_control_fsm_alu_decoder.sv
// Maps the state's ALU class plus opcode/funct onto the 4-bit ALU operation,
// and flags whether an R-type funct is supported.
module alu_decoder
    import mips_pkg::*;
(
    input  alu_class_t  alu_class,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    output logic [3:0]  alu_op,
    output logic        funct_legal
);

    // ALU operation and funct legality decode
    always_comb begin
        alu_op      = ALU_ADD;
        funct_legal = 1'b0;
        case (alu_class)
            CLS_ADD: alu_op = ALU_ADD;
            CLS_SUB: alu_op = ALU_SUB;
            CLS_FUNCT: begin
                funct_legal = 1'b1;
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: funct_legal = 1'b0;
                endcase
            end
            CLS_IMM: begin
                case (opcode)
                    OP_ANDI: alu_op = ALU_AND;
                    OP_ORI:  alu_op = ALU_OR;
                    default: alu_op = ALU_ADD;
                endcase
            end
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle control sequencer for the merged-memory MIPS datapath: steps each
// instruction through its states and drives all selects and write strobes.
module mc_control_fsm
    import mips_pkg::*;
#(
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               iord,
    output logic               mem_write,
    output logic               ir_write,
    output logic               pc_en,
    output logic [1:0]         pc_src,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               ext_sel,
    output logic               reg_dst,
    output logic               mem2reg,
    output logic               reg_write,
    output logic               retire,
    output logic               illegal,
    output logic [3:0]         state_o
);

    state_t     state;
    state_t     state_next;
    alu_class_t alu_class;
    logic [3:0] dec_alu_op;
    logic       funct_legal;
    logic       pc_write;
    logic       branch;
    logic       raw_mem_req;
    logic       raw_mem_write;
    logic       raw_ir_write;
    logic       raw_reg_write;
    logic       raw_retire;
    logic       raw_illegal;

    alu_decoder u_alu_decoder (
        .alu_class   (alu_class),
        .opcode      (opcode),
        .funct       (funct),
        .alu_op      (dec_alu_op),
        .funct_legal (funct_legal)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        state_next    = state;
        raw_mem_req   = 1'b0;
        raw_mem_write = 1'b0;
        raw_ir_write  = 1'b0;
        raw_reg_write = 1'b0;
        raw_retire    = 1'b0;
        raw_illegal   = 1'b0;
        pc_write      = 1'b0;
        branch        = 1'b0;
        iord          = 1'b0;
        pc_src        = PCSRC_ALU;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_FOUR;
        alu_class     = CLS_ADD;
        ext_sel       = 1'b1;
        reg_dst       = 1'b0;
        mem2reg       = 1'b0;
        case (state)
            S_FETCH: begin
                raw_mem_req  = 1'b1;
                raw_ir_write = mem_ready;
                pc_write     = mem_ready;
                if (mem_ready) state_next = S_DECODE;
                else           state_next = S_FETCH;
            end
            S_DECODE: begin
                // Branch target is precomputed here into the ALU register
                alu_src_b = SRCB_IMM_SH2;
                case (opcode)
                    OP_LW, OP_SW:              state_next = S_MEMADR;
                    OP_RTYPE:                  state_next = S_EXECUTE;
                    OP_BEQ:                    state_next = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI:  state_next = S_IMMEX;
                    OP_J:                      state_next = S_JUMP;
                    default: begin
                        raw_illegal = 1'b1;
                        state_next  = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                if (opcode == OP_LW) state_next = S_MEMRD;
                else                 state_next = S_MEMWR;
            end
            S_MEMRD: begin
                raw_mem_req = 1'b1;
                iord        = 1'b1;
                if (mem_ready) state_next = S_MEMWB;
                else           state_next = S_MEMRD;
            end
            S_MEMWB: begin
                raw_reg_write = 1'b1;
                mem2reg       = 1'b1;
                raw_retire    = 1'b1;
                state_next    = S_FETCH;
            end
            S_MEMWR: begin
                raw_mem_req   = 1'b1;
                iord          = 1'b1;
                raw_mem_write = 1'b1;
                if (mem_ready) begin
                    raw_retire = 1'b1;
                    state_next = S_FETCH;
                end else begin
                    state_next = S_MEMWR;
                end
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_REG;
                alu_class = CLS_FUNCT;
                if (funct_legal) begin
                    state_next = S_ALUWB;
                end else begin
                    raw_illegal = 1'b1;
                    state_next  = S_FETCH;
                end
            end
            S_ALUWB: begin
                raw_reg_write = 1'b1;
                reg_dst       = 1'b1;
                raw_retire    = 1'b1;
                state_next    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_REG;
                alu_class  = CLS_SUB;
                branch     = 1'b1;
                pc_src     = PCSRC_ALUREG;
                raw_retire = 1'b1;
                state_next = S_FETCH;
            end
            S_IMMEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                alu_class  = CLS_IMM;
                ext_sel    = (opcode == OP_ADDI);
                state_next = S_IMMWB;
            end
            S_IMMWB: begin
                alu_class     = CLS_IMM;
                ext_sel       = (opcode == OP_ADDI);
                raw_reg_write = 1'b1;
                raw_retire    = 1'b1;
                state_next    = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_src     = PCSRC_JUMP;
                raw_retire = 1'b1;
                state_next = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase
    end

    // Strobes are gated by rst so nothing writes while reset is held
    assign mem_req   = raw_mem_req & ~rst;
    assign mem_write = raw_mem_write & ~rst;
    assign ir_write  = raw_ir_write & ~rst;
    assign reg_write = raw_reg_write & ~rst;
    assign retire    = raw_retire & ~rst;
    assign illegal   = raw_illegal & ~rst;
    assign pc_en     = (pc_write | (branch & zero)) & ~rst;
    assign alu_op    = ALUOP_W'(dec_alu_op);
    assign state_o   = state;

endmodule
